// File: rtl/ldl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ldl_rr_arbiter
//   Round-robin arbiter with grant tenure limit. One requester at a time holds
//   the resource until it signals done or until MAX_HOLD cycles elapse, at
//   which point it is forcibly released and timeout pulses for one cycle.
//   Priority rotates to the requester just after the last holder, so every
//   active requester is served within WIDTH grants. Arbitration happens only
//   in IDLE, which leaves one bubble cycle between consecutive grants.
// ---------------------------------------------------------------------------
module ldl_rr_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         req,
    input  logic                     done,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] gnt_id,
    output logic                     gnt_vld,
    output logic                     timeout
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(MAX_HOLD + 1);

    // WIDTH held one bit wider than an index so index sums never overflow.
    localparam logic [IW:0]   WIDTH_W   = (IW + 1)'(WIDTH);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Registered state and outputs.
    state_t          state_q,   state_d;
    logic [IW-1:0]   ptr_q,     ptr_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0] gnt_q,    gnt_d;
    logic [IW-1:0]   gnt_id_q,  gnt_id_d;
    logic            gnt_vld_q, gnt_vld_d;
    logic            timeout_q, timeout_d;

    // Arbitration datapath.
    logic [WIDTH-1:0] rot_req;
    logic [IW-1:0]    low_idx;
    logic [IW-1:0]    winner;
    logic [WIDTH-1:0] winner_oh;
    logic             any_req;

    // (a + b) mod WIDTH for a, b < WIDTH; correct for non-power-of-2 WIDTH
    // because the sum is formed one bit wider and reduced by a single subtract.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a,
                                               input logic [IW-1:0] b);
        logic [IW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= WIDTH_W) begin
            s = s - WIDTH_W;
        end
        return IW'(s);
    endfunction

    // Rotate req right by ptr so the highest-priority requester sits at bit 0,
    // then pick the lowest set bit and map it back to an absolute index.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        rot_req   = '0;
        low_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rot_req[i] = req[wrap_add(IW'(i), ptr_q)];
        end
        // Scanning downward lets the last hit be the lowest set bit.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                low_idx = IW'(i);
            end
        end
        any_req   = |req;
        winner    = wrap_add(low_idx, ptr_q);
        winner_oh = {{(WIDTH-1){1'b0}}, 1'b1} << winner;
    end

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                // done is meaningless without a holder and is ignored here.
                if (any_req) begin
                    state_d   = GRANT;
                    gnt_d     = winner_oh;
                    gnt_id_d  = winner;
                    gnt_vld_d = 1'b1;
                    cnt_d     = '0;
                end
            end

            GRANT: begin
                // Outputs are frozen while held; req is not looked at here.
                if (done || (cnt_q == HOLD_LAST)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    gnt_vld_d = 1'b0;
                    cnt_d     = '0;
                    ptr_d     = wrap_add(gnt_id_q, IW'(1));
                    // A voluntary release on the last hold cycle is not a timeout.
                    timeout_d = ~done;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge value of its inputs. Reset is checked first so it
        // overrides done, req and a pending timeout in the same cycle.
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

    // Structural invariants of the grant outputs.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt_q));
    a_vld_matches : assert property (@(posedge clk) disable iff (rst)
        gnt_vld_q == (|gnt_q));
    a_timeout_released : assert property (@(posedge clk) disable iff (rst)
        timeout_q |-> !gnt_vld_q);

endmodule
